dbg_print_port: RTL
===================

// Module: dbg_print_port
// PURPOSE
// - Synthesizable Avalon-MM slave that replaces bench-side snooping of the Nios "acumulador" print writes.
// - Decodes the print command words per channel: char, fixed-point, decimal, cycle count and stop.
// - Queues the decoded records in a FIFO and presents them on a valid/ready stream.
// - The stream feeds the UART/JTAG dumper or the testbench; the block sits beside medidordesempenho in the Qsys system.
// PARAMETERS
// - CHANNELS    4   number of independent print channels, power of 2, >=2; address selects channel.
// - FIFO_DEPTH 16   record FIFO depth, power of 2, >=2.
// - CNT_W      32   width of the internal free-running cycle counter.
// PORTS
// - clk            in   1              system clock.
// - reset_n        in   1              asynchronous active-low reset.
// - avs_address    in   log2(CHANNELS) channel select on write; register select on read.
// - avs_write      in   1              write strobe.
// - avs_writedata  in   32             command or argument word.
// - avs_read       in   1              status read strobe.
// - avs_readdata   out  32             status word; layout under BEHAVIOUR.
// - avs_waitrequest out 1              stalls a write while the FIFO is full.
// - rec_valid      out  1              record available.
// - rec_ready      in   1              consumer accepts record.
// - rec_kind       out  3              0=CHAR, 1=FIXED, 2=DEC, 3=CYCLES, 4=STOP.
// - rec_chan       out  log2(CHANNELS) originating channel.
// - rec_data       out  32             payload.
// - rec_ts         out  CNT_W          timestamp (macro only; tied to 0 without it).
// - done           out  1              sticky: STOP accepted.
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; per-channel pending state IDLE; counter 0; done 0.
// - Accept/consume rules:
//   - A write is accepted when avs_write && !avs_waitrequest.
//   - avs_waitrequest = avs_write && fifo_full && !done. It is combinational and ignores rec_ready in the same cycle.
//   - A read is never stalled. avs_readdata is registered, 1-cycle latency.
// - Per-channel FSM, states IDLE / ARG_FIX / ARG_DEC. Accepted word w on channel c:
//   - IDLE, w==FFFFFFFF: push STOP (data=0). Set done.
//   - IDLE, w==FFFFFFFE: go to ARG_FIX. No push.
//   - IDLE, w==FFFFFFFD: go to ARG_DEC. No push.
//   - IDLE, w==FFFFFFFC: push CYCLES with data = counter[31:0] at accept cycle (zero-extended if CNT_W<32).
//   - IDLE, other w: push CHAR with data = {24'b0, w[7:0]}.
//   - ARG_FIX: push FIXED with data = w raw (consumer scales by 1/100000). Return to IDLE. Any w, including command codes, is the argument.
//   - ARG_DEC: same as ARG_FIX with kind DEC.
// - Channels are independent. A pending argument on one channel does not affect the others.
// - Once done=1, accepted writes are dropped: no push, no state change, waitrequest 0. The FIFO still drains.
// - FIFO timing and boundaries:
//   - Registered. A record pushed at cycle N is visible on rec_valid at N+1 when the FIFO was empty.
//   - The rec_* outputs stay stable while rec_valid && !rec_ready.
//   - Simultaneous push and pop when not full: allowed, level unchanged.
//   - Full: the stalled writer waits. A pop in cycle N releases waitrequest in N+1.
//   - Empty: rec_valid=0 and rec_* hold their last value.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Counter: increments every clk and wraps at 2^CNT_W. It is not stalled by waitrequest.
// - Status read:
//   - avs_address==0: {done, 7'b0, level[7:0], pending_mask[15:0]}, where pending_mask bit c = channel c not IDLE.
//   - avs_address==1: counter[31:0].
//   - Other addresses return 0.
// - Reset asserted mid-operation clears everything immediately. Records still in flight are lost.
// CONFIGURATION
// - DBG_PRINT_PORT_TIMESTAMP_EN defined:
//   - Each FIFO entry also stores counter[CNT_W-1:0] sampled on the accept cycle.
//   - The stored value appears on rec_ts alongside the record.
//   - FIFO width grows by CNT_W.
// - Not defined: no timestamp storage; rec_ts is constant 0.
// TESTING
// - Reset, then write 0x41 and 0x42 on ch0 with rec_ready=1 -> two CHAR records, data 0x41 then 0x42, ch0, first rec_valid 1 cycle after accept.
// - Ch1 writes FFFFFFFE then 0x0001E240 -> one FIXED record, data 123456, ch1. Ch1 writes FFFFFFFD then FFFFFFFF -> DEC record, data FFFFFFFF, done stays 0.
// - Interleave ch0 FFFFFFFE, ch2 0x43, ch0 5 -> CHAR(ch2, 0x43) then FIXED(ch0, 5). Status pending_mask bit0=1 between the two ch0 writes.
// - rec_ready=0, 17 CHAR writes with FIFO_DEPTH=16:
//   - The 17th write sees waitrequest=1 and level reads 16.
//   - Raise rec_ready for 1 cycle -> 17th write accepted next cycle, no record lost, order preserved.
// - Write FFFFFFFC at counter=1000 -> CYCLES data 1000. With DBG_PRINT_PORT_TIMESTAMP_EN, rec_ts = 1000.
// - STOP on ch3 -> STOP record, done=1. A following write 0x44 is dropped. Pulse reset_n low with 3 records queued -> rec_valid=0, done=0, level=0.

Source files
------------

// File: rtl/dbg_print_port.sv
//------------------------------------------------------------------------------
// Module      : dbg_print_port
// Description : Avalon-MM print port. Each channel decodes print command
//               words into CHAR / FIXED / DEC / CYCLES / STOP records. The
//               records go through a FIFO and leave on a valid/ready stream.
// Ports       : clk, reset_n (async, active low)
//               avs_address/write/writedata/read -> avs_readdata, avs_waitrequest
//               rec_valid/rec_ready, rec_kind, rec_chan, rec_data, rec_ts
//               done (sticky once a STOP record is accepted)
// Options     : define DBG_PRINT_PORT_TIMESTAMP_EN to store the cycle counter
//               with each record and present it on rec_ts (otherwise rec_ts=0).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dbg_print_port #(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(CHANNELS)-1:0] avs_address,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    input  logic                        avs_read,
    output logic [31:0]                 avs_readdata,
    output logic                        avs_waitrequest,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output logic [2:0]                  rec_kind,
    output logic [$clog2(CHANNELS)-1:0] rec_chan,
    output logic [31:0]                 rec_data,
    output logic [CNT_W-1:0]            rec_ts,
    output logic                        done
);

    localparam int AW = $clog2(CHANNELS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] KIND_CHAR   = 3'd0;
    localparam logic [2:0] KIND_FIXED  = 3'd1;
    localparam logic [2:0] KIND_DEC    = 3'd2;
    localparam logic [2:0] KIND_CYCLES = 3'd3;
    localparam logic [2:0] KIND_STOP   = 3'd4;

    localparam logic [31:0] CMD_STOP   = 32'hFFFF_FFFF;
    localparam logic [31:0] CMD_FIXED  = 32'hFFFF_FFFE;
    localparam logic [31:0] CMD_DEC    = 32'hFFFF_FFFD;
    localparam logic [31:0] CMD_CYCLES = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARG_FIX = 2'd1,
        ST_ARG_DEC = 2'd2
    } chan_state_t;

    typedef struct packed {
`ifdef DBG_PRINT_PORT_TIMESTAMP_EN
        logic [CNT_W-1:0] ts;
`endif
        logic [2:0]       kind;
        logic [AW-1:0]    chan;
        logic [31:0]      data;
    } rec_t;

    chan_state_t      state_q [CHANNELS];
    chan_state_t      state_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [LW-1:0]    after_pop;
    rec_t             head_q, head_d;
    logic             valid_q, valid_d;
    logic [31:0]      rdata_q, rdata_d;
    rec_t             fifo_mem [FIFO_DEPTH];

    logic [CHANNELS-1:0] pend;
    logic                fifo_full;
    logic                wr_accept;
    logic                push;
    logic                pop;
    rec_t                push_rec;
    logic [31:0]         cnt32;

    // Waitrequest deliberately ignores rec_ready: a slot freed this cycle is
    // only offered to the writer on the next cycle.
    assign fifo_full       = (count_q == LW'(FIFO_DEPTH));
    assign avs_waitrequest = avs_write && fifo_full && !done_q;
    assign wr_accept       = avs_write && !avs_waitrequest;
    assign pop             = valid_q && rec_ready;
    assign cnt32           = 32'(cnt_q);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pend
        assign pend[c] = (state_q[c] != ST_IDLE);
    end

    // Command decode for the addressed channel.
    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        push          = 1'b0;
        push_rec      = '0;
        push_rec.chan = avs_address;
`ifdef DBG_PRINT_PORT_TIMESTAMP_EN
        push_rec.ts   = cnt_q;
`endif
        // After STOP every accepted write is swallowed without effect.
        if (wr_accept && !done_q) begin
            case (state_q[avs_address])
                ST_IDLE: begin
                    if (avs_writedata == CMD_STOP) begin
                        push          = 1'b1;
                        push_rec.kind = KIND_STOP;
                        done_d        = 1'b1;
                    end else if (avs_writedata == CMD_FIXED) begin
                        state_d[avs_address] = ST_ARG_FIX;
                    end else if (avs_writedata == CMD_DEC) begin
                        state_d[avs_address] = ST_ARG_DEC;
                    end else if (avs_writedata == CMD_CYCLES) begin
                        push          = 1'b1;
                        push_rec.kind = KIND_CYCLES;
                        push_rec.data = cnt32;
                    end else begin
                        push          = 1'b1;
                        push_rec.kind = KIND_CHAR;
                        push_rec.data = {24'b0, avs_writedata[7:0]};
                    end
                end
                // Argument words are taken raw, even if they look like commands.
                ST_ARG_FIX: begin
                    push                 = 1'b1;
                    push_rec.kind        = KIND_FIXED;
                    push_rec.data        = avs_writedata;
                    state_d[avs_address] = ST_IDLE;
                end
                ST_ARG_DEC: begin
                    push                 = 1'b1;
                    push_rec.kind        = KIND_DEC;
                    push_rec.data        = avs_writedata;
                    state_d[avs_address] = ST_IDLE;
                end
                default: state_d[avs_address] = ST_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping. The head of the queue is kept in its own register so
    // the outputs are flop-driven and hold their last value when empty.
    always_comb begin
        count_d   = count_q + LW'(push) - LW'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        after_pop = count_q - LW'(pop);
        valid_d   = (count_d != '0);
        head_d    = head_q;
        if (count_d != '0) begin
            // Nothing left behind the popped entry: the new push is the head.
            head_d = (after_pop == '0) ? push_rec : fifo_mem[rd_ptr_d];
        end
    end

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        rdata_d = rdata_q;
        if (avs_read) begin
            if (avs_address == AW'(0)) begin
                rdata_d = {done_q, 7'b0, 8'(count_q), 16'(pend)};
            end else if (avs_address == AW'(1)) begin
                rdata_d = cnt32;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
            end
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: contents are only read behind the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_rec;
        end
    end

    assign avs_readdata = rdata_q;
    assign rec_valid    = valid_q;
    assign rec_kind     = head_q.kind;
    assign rec_chan     = head_q.chan;
    assign rec_data     = head_q.data;
    assign done         = done_q;
`ifdef DBG_PRINT_PORT_TIMESTAMP_EN
    assign rec_ts       = head_q.ts;
`else
    assign rec_ts       = '0;
`endif

endmodule

`default_nettype wire
